// File: rtl/slice_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : slice_logic_unit
// Purpose  : Multi-cycle bitwise logic unit (AND / OR / XOR / NOR) for the
//            Booth multiplier datapath and the ALU. Operands are latched once
//            and then processed SLICE bits per clock, least-significant slice
//            first. Valid/ready handshakes on the input and output sides.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand/result width in bits (multiple of SLICE)
//   SLICE      bits processed per clock, 1 <= SLICE <= WIDTH
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands/op presented
//   in_ready   unit can accept operands (IDLE)
//   x, y       operands A and B
//   op         00 AND, 01 OR, 10 XOR, 11 NOR
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   s          result
//   zero       result is all-zero (only when ZERO_FLAG_EN is defined)
// Build option
//   ZERO_FLAG_EN  adds the zero port and its sticky OR accumulator
// ============================================================================
module slice_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s
`ifdef ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int NSLICE = WIDTH / SLICE;
  // Counter is at least one bit wide so a single-slice build still elaborates.
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // --------------------------------------------------------------------------
  // Configuration check: a partial trailing slice is not supported.
  // --------------------------------------------------------------------------
  generate
    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_cfg_error
      $error("slice_logic_unit: WIDTH (%0d) must be a multiple of SLICE (%0d), 1 <= SLICE <= WIDTH",
             WIDTH, SLICE);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt;

  logic [SLICE-1:0] x_sl;
  logic [SLICE-1:0] y_sl;
  logic [SLICE-1:0] slice_res;
  logic             last_slice;

  // Per-slice logic function; NOR is the per-bit complement of OR.
  function automatic logic [SLICE-1:0] slice_op(
    input logic [1:0]       o,
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b
  );
    logic [SLICE-1:0] r;
    case (o)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Select the current slice of the latched operands.
  always_comb begin
    x_sl = '0;
    y_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        x_sl = x_q[k*SLICE +: SLICE];
        y_sl = y_q[k*SLICE +: SLICE];
      end
    end
  end

  assign slice_res  = slice_op(op_q, x_sl, y_sl);
  assign last_slice = (cnt == LAST_IDX);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (last_slice) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, slice write-back, slice counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      op_q <= '0;
      s_q  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_q  <= x;
            y_q  <= y;
            op_q <= op;
            s_q  <= '0;
            cnt  <= '0;
          end
        end
        ST_BUSY: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (cnt == CW'(k)) begin
              s_q[k*SLICE +: SLICE] <= slice_res;
            end
          end
          if (last_slice) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // DONE: result held until the next accept
        end
      endcase
    end
  end

  assign s = s_q;

`ifdef ZERO_FLAG_EN
  // --------------------------------------------------------------------------
  // Zero flag: sticky OR of every slice written during BUSY.
  // --------------------------------------------------------------------------
  logic acc_or;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_or <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc_or <= 1'b0;
          end
        end
        ST_BUSY: begin
          acc_or <= acc_or | (|slice_res);
        end
        default: begin
        end
      endcase
    end
  end

  // Only meaningful while the result is presented.
  assign zero = (state == ST_DONE) && !acc_or;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slice_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_slice_logic_unit
// Purpose  : Self-checking bench for slice_logic_unit. Two instances share
//            one set of stimulus: WIDTH=32/SLICE=8 and WIDTH=16/SLICE=4
//            (both four slices, so they run in lock-step). Results are
//            compared with a whole-word reference function.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slice_logic_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic [1:0]  op;

  logic        in_ready32, out_valid32;
  logic [31:0] s32;
  logic        in_ready16, out_valid16;
  logic [15:0] s16;
`ifdef ZERO_FLAG_EN
  logic        zero32, zero16;
`endif

  slice_logic_unit #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .x         (x),
    .y         (y),
    .op        (op),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .s         (s32)
`ifdef ZERO_FLAG_EN
    ,
    .zero      (zero32)
`endif
  );

  slice_logic_unit #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .x         (x[15:0]),
    .y         (y[15:0]),
    .op        (op),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .s         (s16)
`ifdef ZERO_FLAG_EN
    ,
    .zero      (zero16)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-word reference behaviour.
  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // One full transaction on both instances. hold = cycles out_ready stays
  // low once the result is presented; x/y/op/in_valid are scrambled while
  // the unit is busy or done to confirm the latched copies are used.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o, input int hold);
    logic [31:0] exp32;
    logic [31:0] w16;
    logic [15:0] exp16;
    int          lat32;
    int          lat16;
    int          waited;

    exp32 = ref_op(o, a, b);
    w16   = ref_op(o, {16'h0, a[15:0]}, {16'h0, b[15:0]});
    exp16 = w16[15:0];

    waited = 0;
    while (!in_ready32 && waited < 20) begin
      tick();
      waited++;
    end
    check("ready_before_accept", {31'b0, in_ready32}, 32'd1);
`ifdef ZERO_FLAG_EN
    check("zero_idle", {31'b0, zero32}, 32'd0);
`endif

    x = a; y = b; op = o; in_valid = 1'b1;
    out_ready = (hold == 0);
    tick();                                  // accept edge

    lat32 = -1;
    lat16 = -1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid32 && lat32 < 0) lat32 = c;
      if (out_valid16 && lat16 < 0) lat16 = c;
      if (lat32 >= 0 && lat16 >= 0) break;
`ifdef ZERO_FLAG_EN
      check("zero_busy", {31'b0, zero32}, 32'd0);
`endif
      check("busy_in_ready", {31'b0, in_ready32}, 32'd0);
      tick();
      x = $urandom; y = $urandom; op = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;

    check("latency32", lat32, 32'd4);
    check("latency16", lat16, 32'd4);
    check("result32", s32, exp32);
    check("result16", {16'h0, s16}, {16'h0, exp16});
    check("done_in_ready", {31'b0, in_ready32}, 32'd0);
`ifdef ZERO_FLAG_EN
    check("zero32", {31'b0, zero32}, {31'b0, (exp32 == 32'h0)});
    check("zero16", {31'b0, zero16}, {31'b0, (exp16 == 16'h0)});
`endif

    for (int h = 0; h < hold; h++) begin
      x = $urandom; y = $urandom; op = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      tick();
      check("hold_valid", {31'b0, out_valid32}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready32}, 32'd0);
      check("hold_result", s32, exp32);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_valid", {31'b0, out_valid32}, 32'd0);
    check("release_in_ready", {31'b0, in_ready32}, 32'd1);
    check("release_result32", s32, exp32);
    check("release_result16", {16'h0, s16}, {16'h0, exp16});
`ifdef ZERO_FLAG_EN
    check("zero_released", {31'b0, zero32}, 32'd0);
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] c16 [4];
    c16[0] = 16'h05C0; c16[1] = 16'hAFF3; c16[2] = 16'hAA33; c16[3] = 16'h500C;

    // Reset held with in_valid asserted: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    x = $urandom; y = $urandom; op = 2'b10;
    repeat (2) tick();
    check("rst_in_ready", {31'b0, in_ready32}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid32}, 32'd0);
    check("rst_s32", s32, 32'h0);
    check("rst_s16", {16'h0, s16}, 32'h0);
`ifdef ZERO_FLAG_EN
    check("rst_zero", {31'b0, zero32}, 32'd0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_idle", {31'b0, in_ready32}, 32'd1);
    check("post_rst_no_op", {31'b0, out_valid32}, 32'd0);

    // XOR at default parameters.
    do_op(32'hF0F0_1234, 32'h0FF0_FFFF, 2'b10, 0);
    check("xor32_const", s32, 32'hFF00_EDCB);

    // All four ops on the 16/4 instance.
    for (int o = 0; o < 4; o++) begin
      do_op(32'h0000_A5C3, 32'h0000_0FF0, 2'(o), 0);
      check("op16_const", {16'h0, s16}, {16'h0, c16[o]});
    end

    // Backpressure with scrambled inputs.
    do_op($urandom, $urandom, 2'($urandom_range(0, 3)), 5);

    // Reset during the second BUSY cycle.
    x = 32'h1234_5678; y = 32'h0F0F_0F0F; op = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_valid", {31'b0, out_valid32}, 32'd0);
    check("abort_s", s32, 32'h0);
    check("abort_in_ready", {31'b0, in_ready32}, 32'd1);
    rst = 1'b0;
    do_op(32'hFFFF_FFFF, 32'h0, 2'b00, 0);
    check("after_abort_and", s32, 32'h0);

    // Zero-result and non-zero-result cases.
    do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 0);
    check("xor_self_zero", s32, 32'h0);
    do_op(32'h0000_0001, 32'h0, 2'b01, 1);

    // Random traffic.
    repeat (24) begin
      do_op($urandom, $urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
